// File: rtl/arp_responder_if.sv
// GMII-style PHY-side byte streams seen by the ARP responder.
// The responder (master) consumes the receive stream and drives its own
// transmit stream; the PHY/MAC side (slave) does the reverse.
interface arp_responder_if;
  logic [7:0] rx_data;
  logic       rx_dv;
  logic       rx_er;
  logic [7:0] tx_data;
  logic       tx_dv;
  logic       tx_er;

  modport master (input rx_data, rx_dv, rx_er, output tx_data, tx_dv, tx_er);
  modport slave  (output rx_data, rx_dv, rx_er, input tx_data, tx_dv, tx_er);
endinterface

// File: rtl/arp_responder.sv
// ARP responder: parses the received byte stream for ARP requests aimed at
// MY_IP and emits a complete 72-byte reply frame (preamble, padding, FCS).
// Byte mode only; with speed=0 the block stays silent.
module arp_responder #(
  parameter logic [47:0] MY_MAC     = 48'h0200_0000_0001,
  parameter logic [31:0] MY_IP      = 32'hC0A8_0001,
  parameter int          IFG_CLOCKS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 speed,
  arp_responder_if.master      gmii,
  output logic [15:0]          reply_cnt
);

  typedef enum logic [1:0] {RX_IDLE, RX_FRAME, RX_DROP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_FRAME, TX_IFG} tx_state_t;

  // Byte k (0 = first on the wire) of a MAC / IP address.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input int k);
    logic [47:0] s;
    s = mac << (8 * k);
    return s[47:40];
  endfunction

  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input int k);
    logic [31:0] s;
    s = ip << (8 * k);
    return s[31:24];
  endfunction

  // Ethertype + fixed ARP header (frame offsets 20..29); only the opcode differs.
  function automatic logic [7:0] arp_hdr(input int k, input logic is_reply);
    logic [7:0] b;
    case (k)
      0: b = 8'h08;  1: b = 8'h06;  2: b = 8'h00;  3: b = 8'h01;
      4: b = 8'h08;  5: b = 8'h00;  6: b = 8'h06;  7: b = 8'h04;
      8: b = 8'h00;  9: b = is_reply ? 8'h02 : 8'h01;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // One byte of reflected CRC-32 (poly EDB88320), LSB of the byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  rx_state_t   rx_state;
  logic [7:0]  rx_cnt;
  logic        bc_ok, uc_ok, bc_next, uc_next, byte_ok;
  logic [47:0] cap_sha, pend_sha, tx_sha;
  logic [31:0] cap_spa, pend_spa, tx_spa;
  logic        pending, frame_done, tx_start;

  tx_state_t   tx_state;
  logic [6:0]  tx_idx;
  logic [7:0]  ifg_cnt;
  logic [31:0] crc_reg, crc_next, fcs_shift;
  logic [7:0]  tx_byte, tx_data_reg;
  logic        tx_dv_reg, tx_er_reg;
  logic [15:0] reply_cnt_reg;

  assign gmii.tx_data = tx_data_reg;
  assign gmii.tx_dv   = tx_dv_reg;
  assign gmii.tx_er   = tx_er_reg;
  assign reply_cnt    = reply_cnt_reg;

  // A frame qualifies only if it ended cleanly after at least 72 bytes.
  assign frame_done = (rx_state == RX_FRAME) && !gmii.rx_dv && (rx_cnt >= 8'd72) && speed;
  assign tx_start   = (tx_state == TX_IDLE) && pending && speed;

  // Match check of the byte at the current receive offset.
  always_comb begin
    byte_ok = 1'b1;
    bc_next = bc_ok;
    uc_next = uc_ok;
    if (rx_cnt == 8'd7) begin
      byte_ok = (gmii.rx_data == 8'hD5);
    end else if (rx_cnt >= 8'd8 && rx_cnt <= 8'd13) begin
      // Destination must be all-broadcast or all ours, never a mix.
      bc_next = ((rx_cnt == 8'd8) ? 1'b1 : bc_ok) && (gmii.rx_data == 8'hFF);
      uc_next = ((rx_cnt == 8'd8) ? 1'b1 : uc_ok) &&
                (gmii.rx_data == mac_byte(MY_MAC, int'(rx_cnt) - 8));
      byte_ok = bc_next || uc_next;
    end else if (rx_cnt >= 8'd20 && rx_cnt <= 8'd29) begin
      byte_ok = (gmii.rx_data == arp_hdr(int'(rx_cnt) - 20, 1'b0));
    end else if (rx_cnt >= 8'd46 && rx_cnt <= 8'd49) begin
      byte_ok = (gmii.rx_data == ip_byte(MY_IP, int'(rx_cnt) - 46));
    end
  end

  // Receive FSM: offset counting, matching, SHA/SPA capture, pending slot data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= 8'd0;
      bc_ok    <= 1'b0;
      uc_ok    <= 1'b0;
      cap_sha  <= 48'h0;
      cap_spa  <= 32'h0;
      pend_sha <= 48'h0;
      pend_spa <= 32'h0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (gmii.rx_dv) begin
            rx_cnt   <= 8'd1;
            rx_state <= (gmii.rx_er || !speed) ? RX_DROP : RX_FRAME;
          end
        end
        RX_FRAME: begin
          if (!gmii.rx_dv) begin
            rx_state <= RX_IDLE;
            if (frame_done) begin
              pend_sha <= cap_sha;
              pend_spa <= cap_spa;
            end
          end else if (gmii.rx_er || !speed || !byte_ok) begin
            rx_state <= RX_DROP;
          end else begin
            bc_ok <= bc_next;
            uc_ok <= uc_next;
            if (rx_cnt != 8'hFF) rx_cnt <= rx_cnt + 8'd1;
            if (rx_cnt >= 8'd30 && rx_cnt <= 8'd35) cap_sha <= {cap_sha[39:0], gmii.rx_data};
            if (rx_cnt >= 8'd36 && rx_cnt <= 8'd39) cap_spa <= {cap_spa[23:0], gmii.rx_data};
          end
        end
        RX_DROP: begin
          if (!gmii.rx_dv) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Pending flag: a new request beats the transmitter's clear, so the
  // latest request survives a same-cycle hand-off.
  always_ff @(posedge clk) begin
    if (rst || !speed)   pending <= 1'b0;
    else if (frame_done) pending <= 1'b1;
    else if (tx_start)   pending <= 1'b0;
  end

  // Reply byte for the current transmit index.
  always_comb begin
    tx_byte   = 8'h00;
    fcs_shift = 32'h0;
    if (tx_idx <= 7'd6)                          tx_byte = 8'h55;
    else if (tx_idx == 7'd7)                     tx_byte = 8'hD5;
    else if (tx_idx <= 7'd13)                    tx_byte = mac_byte(tx_sha, int'(tx_idx) - 8);
    else if (tx_idx <= 7'd19)                    tx_byte = mac_byte(MY_MAC, int'(tx_idx) - 14);
    else if (tx_idx <= 7'd29)                    tx_byte = arp_hdr(int'(tx_idx) - 20, 1'b1);
    else if (tx_idx <= 7'd35)                    tx_byte = mac_byte(MY_MAC, int'(tx_idx) - 30);
    else if (tx_idx <= 7'd39)                    tx_byte = ip_byte(MY_IP, int'(tx_idx) - 36);
    else if (tx_idx <= 7'd45)                    tx_byte = mac_byte(tx_sha, int'(tx_idx) - 40);
    else if (tx_idx <= 7'd49)                    tx_byte = ip_byte(tx_spa, int'(tx_idx) - 46);
    else if (tx_idx >= 7'd68 && tx_idx <= 7'd71) begin
      fcs_shift = ~crc_reg >> (8 * (int'(tx_idx) - 68));
      tx_byte   = fcs_shift[7:0];
    end
  end

  assign crc_next = crc_byte(crc_reg, tx_byte);

  // Transmit FSM with registered outputs; byte 0 leaves on the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state      <= TX_IDLE;
      tx_idx        <= 7'd0;
      ifg_cnt       <= 8'd0;
      crc_reg       <= 32'hFFFF_FFFF;
      tx_sha        <= 48'h0;
      tx_spa        <= 32'h0;
      tx_data_reg   <= 8'h00;
      tx_dv_reg     <= 1'b0;
      tx_er_reg     <= 1'b0;
      reply_cnt_reg <= 16'h0;
    end else begin
      tx_er_reg <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          tx_data_reg <= 8'h00;
          tx_dv_reg   <= 1'b0;
          if (tx_start) begin
            tx_sha      <= pend_sha;
            tx_spa      <= pend_spa;
            tx_data_reg <= 8'h55;
            tx_dv_reg   <= 1'b1;
            tx_idx      <= 7'd1;
            crc_reg     <= 32'hFFFF_FFFF;
            tx_state    <= TX_FRAME;
            if (reply_cnt_reg != 16'hFFFF) reply_cnt_reg <= reply_cnt_reg + 16'd1;
          end
        end
        TX_FRAME: begin
          tx_data_reg <= tx_byte;
          tx_dv_reg   <= 1'b1;
          if (tx_idx >= 7'd8 && tx_idx <= 7'd67) crc_reg <= crc_next;
          if (tx_idx == 7'd71) begin
            ifg_cnt  <= 8'd0;
            tx_state <= TX_IFG;
          end else begin
            tx_idx <= tx_idx + 7'd1;
          end
        end
        TX_IFG: begin
          tx_data_reg <= 8'h00;
          tx_dv_reg   <= 1'b0;
          if (ifg_cnt == 8'(IFG_CLOCKS - 1)) tx_state <= TX_IDLE;
          else                              ifg_cnt  <= ifg_cnt + 8'd1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_responder.sv
// Self-checking bench for arp_responder: randomized ARP requests against a
// frame-level reference model (reply layout + bitwise CRC-32) and an
// event-level model of the pending slot / reply spacing.
module tb_arp_responder;
  localparam logic [47:0] MY_MAC = 48'h0200_0000_0001;
  localparam logic [31:0] MY_IP  = 32'hC0A8_0001;
  localparam int          IFG    = 12;
  localparam int          SLOT   = 72 + IFG;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        speed = 1'b1;
  logic [15:0] reply_cnt;

  arp_responder_if gmii ();

  arp_responder #(.MY_MAC(MY_MAC), .MY_IP(MY_IP), .IFG_CLOCKS(IFG)) dut (
    .clk(clk), .rst(rst), .speed(speed), .gmii(gmii), .reply_cnt(reply_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int cyc = 0;

  // Edge counter; read only at negedges.
  always begin
    @(posedge clk);
    cyc++;
  end

  // Transmit monitor: records every frame (rise edge, start, length).
  logic [7:0] all_bytes[$];
  int f_start[$], f_len[$], f_rise[$];
  int cur_len = 0;
  int tx_er_seen = 0;
  logic prev_dv = 1'b0;
  always begin
    @(negedge clk);
    if (gmii.tx_er) tx_er_seen++;
    if (gmii.tx_dv) begin
      if (!prev_dv) begin
        f_start.push_back(all_bytes.size());
        f_rise.push_back(cyc);
        cur_len = 0;
      end
      all_bytes.push_back(gmii.tx_data);
      cur_len++;
    end else if (prev_dv) begin
      f_len.push_back(cur_len);
    end
    prev_dv = gmii.tx_dv;
  end

  logic [7:0] rx_q[$];

  // Build an ARP request frame (preamble included) into rx_q.
  task automatic build_req(input bit bcast, input logic [47:0] sha, input logic [31:0] spa,
                           input logic [31:0] tpa, input int len);
    logic [7:0] hdr[10];
    hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01};
    rx_q = {};
    for (int i = 0; i < 7; i++) rx_q.push_back(8'h55);
    rx_q.push_back(8'hD5);
    for (int k = 0; k < 6; k++) rx_q.push_back(bcast ? 8'hFF : MY_MAC[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) rx_q.push_back(sha[47-8*k -: 8]);
    for (int k = 0; k < 10; k++) rx_q.push_back(hdr[k]);
    for (int k = 0; k < 6; k++) rx_q.push_back(sha[47-8*k -: 8]);
    for (int k = 0; k < 4; k++) rx_q.push_back(spa[31-8*k -: 8]);
    for (int k = 0; k < 6; k++) rx_q.push_back(8'($urandom));
    for (int k = 0; k < 4; k++) rx_q.push_back(tpa[31-8*k -: 8]);
    while (rx_q.size() < len) rx_q.push_back(8'($urandom));
  endtask

  // Drive rx_q; t_end is the edge that samples rx_dv=0 after the frame.
  task automatic send_frame(input int er_at, output int t_end);
    for (int i = 0; i < rx_q.size(); i++) begin
      @(negedge clk);
      gmii.rx_dv   = 1'b1;
      gmii.rx_data = rx_q[i];
      gmii.rx_er   = (i == er_at);
    end
    @(negedge clk);
    gmii.rx_dv   = 1'b0;
    gmii.rx_er   = 1'b0;
    gmii.rx_data = 8'h00;
    t_end = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait until n frames have completed, at most budget clocks.
  task automatic wait_frames(input int n, input int budget, output bit ok);
    int b;
    b = 0;
    while (f_len.size() < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    ok = (f_len.size() >= n);
  endtask

  // Number of bytes of frame fi that differ from the reference reply.
  function automatic int frame_diff(input int fi, input logic [47:0] sha, input logic [31:0] spa);
    logic [7:0] e[$];
    logic [7:0] hdr[10];
    logic [31:0] c;
    bit fb;
    int n;
    hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02};
    for (int i = 0; i < 7; i++) e.push_back(8'h55);
    e.push_back(8'hD5);
    for (int k = 0; k < 6; k++) e.push_back(sha[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) e.push_back(MY_MAC[47-8*k -: 8]);
    for (int k = 0; k < 10; k++) e.push_back(hdr[k]);
    for (int k = 0; k < 6; k++) e.push_back(MY_MAC[47-8*k -: 8]);
    for (int k = 0; k < 4; k++) e.push_back(MY_IP[31-8*k -: 8]);
    for (int k = 0; k < 6; k++) e.push_back(sha[47-8*k -: 8]);
    for (int k = 0; k < 4; k++) e.push_back(spa[31-8*k -: 8]);
    for (int k = 0; k < 18; k++) e.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < 68; i++)
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ e[i][j];
        c = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    c = ~c;
    for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
    n = 0;
    for (int i = 0; i < 72; i++)
      if (i >= f_len[fi] || all_bytes[f_start[fi] + i] !== e[i]) n++;
    if (f_len[fi] > 72) n += f_len[fi] - 72;
    return n;
  endfunction

  task automatic test_reset();
    idle(3);
    rst = 1'b0;
    idle(1);
    checks++; if (gmii.tx_dv !== 1'b0) begin errors++; $display("FAIL reset_tx_dv: got %b want 0", gmii.tx_dv); end
    checks++; if (gmii.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", gmii.tx_data); end
    checks++; if (gmii.tx_er !== 1'b0) begin errors++; $display("FAIL reset_tx_er: got %b want 0", gmii.tx_er); end
    checks++; if (reply_cnt !== 16'd0) begin errors++; $display("FAIL reset_reply_cnt: got %0d want 0", reply_cnt); end
    $display("reset: outputs idle");
  endtask

  task automatic test_basic();
    logic [47:0] sha;
    logic [31:0] spa;
    int t, base, len, d;
    bit ok, bcast;
    for (int n = 0; n < 4; n++) begin
      if (n == 0) begin
        sha = 48'h0011_2233_4455; spa = 32'hC0A8_0002; len = 72; bcast = 1'b1;
      end else begin
        sha = 48'({$urandom, $urandom}); spa = $urandom; len = 72 + $urandom_range(0, 40);
        bcast = 1'($urandom_range(0, 1));
      end
      base = f_len.size();
      build_req(bcast, sha, spa, MY_IP, len);
      send_frame(-1, t);
      exp_cnt++;
      wait_frames(base + 1, 300, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL basic_reply_%0d: got no reply want one", n);
      end else begin
        d = frame_diff(base, sha, spa);
        checks++; if (f_rise[base] !== t + 1) begin errors++; $display("FAIL basic_latency_%0d: got rise at %0d want %0d", n, f_rise[base], t + 1); end
        checks++; if (f_len[base] !== 72) begin errors++; $display("FAIL basic_len_%0d: got %0d want 72", n, f_len[base]); end
        checks++; if (d !== 0) begin errors++; $display("FAIL basic_content_%0d: got %0d bad bytes want 0", n, d); end
      end
      checks++; if (reply_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL basic_reply_cnt_%0d: got %0d want %0d", n, reply_cnt, exp_cnt); end
      $display("basic %0d: sha=%h spa=%h len=%0d bcast=%0d", n, sha, spa, len, bcast);
      idle(20);
    end
  endtask

  task automatic test_wrong_ip();
    int offs[] = '{7, 8, 9, 10, 11, 12, 13, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 46, 47, 48, 49};
    int t, base, o;
    for (int n = 0; n < 5; n++) begin
      base = f_rise.size();
      if (n == 0) begin
        build_req(1'b1, 48'h0011_2233_4455, 32'hC0A8_0002, 32'hC0A8_0009, 72);
        o = 46;
      end else begin
        build_req(1'($urandom_range(0, 1)), 48'({$urandom, $urandom}), $urandom, MY_IP, 72);
        o = offs[$urandom_range(0, offs.size() - 1)];
        rx_q[o] = rx_q[o] ^ 8'($urandom_range(1, 255));
      end
      send_frame(-1, t);
      idle(150);
      checks++; if (f_rise.size() !== base) begin errors++; $display("FAIL mismatch_no_reply_%0d: got %0d replies want 0", n, f_rise.size() - base); end
      checks++; if (reply_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL mismatch_reply_cnt_%0d: got %0d want %0d", n, reply_cnt, exp_cnt); end
      $display("mismatch %0d: corrupted offset %0d", n, o);
    end
  endtask

  task automatic test_err_short();
    int t, base, er_at, len;
    for (int n = 0; n < 3; n++) begin
      base = f_rise.size();
      er_at = -1; len = 72;
      if (n == 0) er_at = 30;
      else if (n == 1) len = 70;
      else er_at = $urandom_range(0, 71);
      build_req(1'b1, 48'({$urandom, $urandom}), $urandom, MY_IP, len);
      send_frame(er_at, t);
      idle(150);
      checks++; if (f_rise.size() !== base) begin errors++; $display("FAIL err_short_no_reply_%0d: got %0d replies want 0", n, f_rise.size() - base); end
      $display("err/short %0d: er_at=%0d len=%0d", n, er_at, len);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 12;
    logic [47:0] sha[N];
    logic [31:0] spa[N];
    int t_end[N];
    int exp_rise[$], exp_req[$];
    int base, pend, free_at, got, fi, d;
    base = f_rise.size();
    for (int i = 0; i < N; i++) begin
      sha[i] = 48'({$urandom, $urandom});
      spa[i] = (i == N - 2) ? 32'hC0A8_0002 : (i == N - 1) ? 32'hC0A8_0003 : $urandom;
      build_req(1'b1, sha[i], spa[i], MY_IP, 72);
      send_frame(-1, t_end[i]);
      idle($urandom_range(0, 1));
    end
    idle(400);
    // Event model: the transmitter samples the slot before a same-edge
    // completion lands in it; each reply occupies 72+IFG edges.
    pend = -1; free_at = 0;
    for (int e = t_end[0]; e <= t_end[N-1] + 3 * SLOT; e++) begin
      if (pend >= 0 && e >= free_at) begin
        exp_rise.push_back(e); exp_req.push_back(pend);
        pend = -1; free_at = e + SLOT;
      end
      for (int i = 0; i < N; i++) if (t_end[i] == e) pend = i;
    end
    exp_cnt += exp_rise.size();
    got = f_rise.size() - base;
    checks++; if (got !== exp_rise.size()) begin errors++; $display("FAIL b2b_count: got %0d replies want %0d", got, exp_rise.size()); end
    for (int k = 0; k < exp_rise.size() && k < got && base + k < f_len.size(); k++) begin
      fi = base + k;
      d = frame_diff(fi, sha[exp_req[k]], spa[exp_req[k]]);
      checks++; if (f_rise[fi] !== exp_rise[k]) begin errors++; $display("FAIL b2b_rise_%0d: got %0d want %0d", k, f_rise[fi], exp_rise[k]); end
      checks++; if (d !== 0) begin errors++; $display("FAIL b2b_content_%0d: got %0d bad bytes want 0 (spa %h)", k, d, spa[exp_req[k]]); end
      $display("b2b reply %0d: rise=%0d spa=%h", k, f_rise[fi], spa[exp_req[k]]);
    end
    checks++; if (reply_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL b2b_reply_cnt: got %0d want %0d", reply_cnt, exp_cnt); end
  endtask

  task automatic test_speed0();
    int t, base;
    base = f_rise.size();
    speed = 1'b0;
    build_req(1'b1, 48'({$urandom, $urandom}), $urandom, MY_IP, 72);
    send_frame(-1, t);
    idle(100);
    speed = 1'b1;
    idle(100);
    checks++; if (f_rise.size() !== base) begin errors++; $display("FAIL speed0_no_reply: got %0d replies want 0", f_rise.size() - base); end
    checks++; if (reply_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL speed0_reply_cnt: got %0d want %0d", reply_cnt, exp_cnt); end
    $display("speed0: request ignored");
  endtask

  task automatic test_speed_fall();
    logic [47:0] sha;
    logic [31:0] spa;
    int t, base, b, d;
    bit ok;
    base = f_rise.size();
    sha = 48'({$urandom, $urandom}); spa = $urandom;
    build_req(1'b0, sha, spa, MY_IP, 72);
    send_frame(-1, t);
    exp_cnt++;
    b = 0;
    while (f_rise.size() <= base && b < 20) begin @(negedge clk); b++; end
    checks++;
    if (f_rise.size() <= base) begin
      errors++; $display("FAIL speed_fall_start: got no reply want one");
    end else begin
      while (cyc < f_rise[base] + 30) @(negedge clk);
      speed = 1'b0;
      wait_frames(base + 1, 200, ok);
      speed = 1'b1;
      checks++;
      if (!ok) begin
        errors++; $display("FAIL speed_fall_end: got unfinished frame want 72 bytes");
      end else begin
        d = frame_diff(base, sha, spa);
        checks++; if (f_len[base] !== 72) begin errors++; $display("FAIL speed_fall_len: got %0d want 72", f_len[base]); end
        checks++; if (d !== 0) begin errors++; $display("FAIL speed_fall_content: got %0d bad bytes want 0", d); end
      end
    end
    idle(30);
    checks++; if (reply_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL speed_fall_reply_cnt: got %0d want %0d", reply_cnt, exp_cnt); end
    $display("speed fall: frame of %0d bytes", (f_len.size() > base) ? f_len[base] : 0);
  endtask

  task automatic test_reset_mid();
    logic [47:0] sha;
    logic [31:0] spa;
    int t, base, b, d;
    bit ok;
    base = f_rise.size();
    build_req(1'b1, 48'({$urandom, $urandom}), $urandom, MY_IP, 72);
    send_frame(-1, t);
    b = 0;
    while (f_rise.size() <= base && b < 20) begin @(negedge clk); b++; end
    checks++;
    if (f_rise.size() <= base) begin
      errors++; $display("FAIL reset_mid_start: got no reply want one");
    end else begin
      while (cyc < f_rise[base] + 40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      checks++; if (gmii.tx_dv !== 1'b0) begin errors++; $display("FAIL reset_mid_tx_dv: got %b want 0", gmii.tx_dv); end
      checks++; if (reply_cnt !== 16'd0) begin errors++; $display("FAIL reset_mid_reply_cnt: got %0d want 0", reply_cnt); end
    end
    idle(200);
    checks++; if (f_rise.size() !== base + 1) begin errors++; $display("FAIL reset_mid_silent: got %0d frames want 1", f_rise.size() - base); end
    $display("reset mid-reply: frame cut");
    // A fresh request after the abandoned frame is served normally.
    base = f_rise.size();
    sha = 48'({$urandom, $urandom}); spa = $urandom;
    build_req(1'b0, sha, spa, MY_IP, 80);
    send_frame(-1, t);
    exp_cnt++;
    wait_frames(base + 1, 300, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL after_reset_reply: got no reply want one");
    end else begin
      d = frame_diff(base, sha, spa);
      checks++; if (d !== 0) begin errors++; $display("FAIL after_reset_content: got %0d bad bytes want 0", d); end
    end
    checks++; if (reply_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL after_reset_reply_cnt: got %0d want %0d", reply_cnt, exp_cnt); end
    $display("after reset: reply spa=%h", spa);
  endtask

  initial begin
    gmii.rx_data = 8'h00;
    gmii.rx_dv   = 1'b0;
    gmii.rx_er   = 1'b0;
    test_reset();
    test_basic();
    test_wrong_ip();
    test_err_short();
    test_back_to_back();
    test_speed0();
    test_speed_fall();
    test_reset_mid();
    idle(20);
    checks++; if (tx_er_seen !== 0) begin errors++; $display("FAIL tx_er_low: got %0d high cycles want 0", tx_er_seen); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
